// File: rtl/reg_file_2r1w_if.sv
// Access bus of the two-read / one-write register file.
// A write or read is accepted on a rising edge where its strobe (w_en, r_en0, r_en1) and ready are both 1;
// there is no other backpressure. Each accepted read gives exactly one r_valid pulse on the next cycle.
interface reg_file_2r1w_if #(
  parameter int addr_width = 3,
  parameter int data_width = 16
) ();
  logic                      clr;
  logic                      ready;
  logic                      w_en;
  logic [addr_width-1:0]     w_addr;
  logic [data_width/8-1:0]   w_be;
  logic [data_width-1:0]     w_data;
  logic                      r_en0;
  logic                      r_en1;
  logic [addr_width-1:0]     r_addr0;
  logic [addr_width-1:0]     r_addr1;
  logic [data_width-1:0]     r_data0;
  logic [data_width-1:0]     r_data1;
  logic                      r_valid0;
  logic                      r_valid1;
  logic                      dbg_state;  // 1 while the clear sweep runs

  modport master (
    output clr, w_en, w_addr, w_be, w_data, r_en0, r_en1, r_addr0, r_addr1,
    input  ready, r_data0, r_data1, r_valid0, r_valid1, dbg_state
  );

  modport slave (
    input  clr, w_en, w_addr, w_be, w_data, r_en0, r_en1, r_addr0, r_addr1,
    output ready, r_data0, r_data1, r_valid0, r_valid1, dbg_state
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered reads, byte enables,
// optional write-to-read forwarding and a zeroing sweep after reset or clr.
module reg_file_2r1w #(
  parameter int addr_width = 3,
  parameter int data_width = 16,
  parameter bit bypass     = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  reg_file_2r1w_if.slave bus
);
  localparam int depth   = 1 << addr_width;
  localparam int n_bytes = data_width / 8;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                state;
  logic [addr_width-1:0] cnt;
  logic                  ready_q;
  logic [data_width-1:0] r_data0_q, r_data1_q;
  logic                  r_valid0_q, r_valid1_q;
  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] w_word;
  logic [data_width-1:0] rd_word0, rd_word1;
  logic                  w_fire;

  assign w_fire = (state == S_IDLE) && bus.w_en;

  // Post-write contents of the addressed entry; equals the old word when w_be is 0.
  always_comb begin
    w_word = mem[bus.w_addr];
    for (int i = 0; i < n_bytes; i++) begin
      if (bus.w_be[i]) w_word[8*i +: 8] = bus.w_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word0 = mem[bus.r_addr0];
    rd_word1 = mem[bus.r_addr1];
    if (bypass && w_fire && (bus.w_addr == bus.r_addr0)) rd_word0 = w_word;
    if (bypass && w_fire && (bus.w_addr == bus.r_addr1)) rd_word1 = w_word;
  end

  // Storage has no reset; the sweep establishes the zero state.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (w_fire) begin
      mem[bus.w_addr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      ready_q    <= 1'b0;
      r_data0_q  <= '0;
      r_data1_q  <= '0;
      r_valid0_q <= 1'b0;
      r_valid1_q <= 1'b0;
    end else begin
      r_valid0_q <= 1'b0;
      r_valid1_q <= 1'b0;
      case (state)
        S_CLEAR: begin
          cnt <= cnt + addr_width'(1);
          if (&cnt) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          r_valid0_q <= bus.r_en0;
          r_valid1_q <= bus.r_en1;
          if (bus.r_en0) r_data0_q <= rd_word0;
          if (bus.r_en1) r_data1_q <= rd_word1;
          // Accesses in the clr cycle still complete; the sweep then zeroes everything.
          if (bus.clr) begin
            state   <= S_CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.r_data0   = r_data0_q;
  assign bus.r_data1   = r_data1_q;
  assign bus.r_valid0  = r_valid0_q;
  assign bus.r_valid1  = r_valid1_q;
  assign bus.dbg_state = (state == S_CLEAR);
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: two instances (forwarding on and off) share one stimulus
// stream and are checked against an array model of the register file.
module tb_reg_file_2r1w;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          clr = 1'b0, w_en = 1'b0, r_en0 = 1'b0, r_en1 = 1'b0;
  logic [AW-1:0] w_addr = '0, r_addr0 = '0, r_addr1 = '0;
  logic [NB-1:0] w_be = '0;
  logic [DW-1:0] w_data = '0;

  reg_file_2r1w_if #(.addr_width(AW), .data_width(DW)) bus1 ();
  reg_file_2r1w_if #(.addr_width(AW), .data_width(DW)) bus0 ();

  assign bus1.clr = clr;     assign bus0.clr = clr;
  assign bus1.w_en = w_en;   assign bus0.w_en = w_en;
  assign bus1.w_addr = w_addr; assign bus0.w_addr = w_addr;
  assign bus1.w_be = w_be;   assign bus0.w_be = w_be;
  assign bus1.w_data = w_data; assign bus0.w_data = w_data;
  assign bus1.r_en0 = r_en0; assign bus0.r_en0 = r_en0;
  assign bus1.r_en1 = r_en1; assign bus0.r_en1 = r_en1;
  assign bus1.r_addr0 = r_addr0; assign bus0.r_addr0 = r_addr0;
  assign bus1.r_addr1 = r_addr1; assign bus0.r_addr1 = r_addr1;

  reg_file_2r1w #(.addr_width(AW), .data_width(DW), .bypass(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );
  reg_file_2r1w #(.addr_width(AW), .data_width(DW), .bypass(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  // ---------------- reference model / scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left = DEPTH;  // cycles of not-ready still to come
  logic [DW-1:0] exp_q [$];           // order per edge: fwd p0, fwd p1, nofwd p0, nofwd p1
  logic [DW-1:0] hold [2][2];         // last delivered word per [instance][port]

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [NB-1:0] be);
    logic [DW-1:0] mask = '0;
    for (int i = 0; i < NB; i++) if (be[i]) mask = mask | (DW'(8'hFF) << (8 * i));
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic start_clear();
    clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic check_port(string tag, logic valid, logic [DW-1:0] data, bit exp_valid, int d, int p);
    check({tag, "_valid"}, 32'(valid), 32'(exp_valid));
    if (exp_valid) hold[d][p] = exp_q.pop_front();
    check({tag, "_data"}, 32'(data), 32'(hold[d][p]));
  endtask

  task automatic check_outputs(bit rd0, bit rd1);
    check("ready_fwd", 32'(bus1.ready), 32'(clear_left == 0));
    check("ready_nofwd", 32'(bus0.ready), 32'(clear_left == 0));
    check("state_fwd", 32'(bus1.dbg_state), 32'(clear_left > 0));
    check_port("fwd_p0", bus1.r_valid0, bus1.r_data0, rd0, 1, 0);
    check_port("fwd_p1", bus1.r_valid1, bus1.r_data1, rd1, 1, 1);
    check_port("nofwd_p0", bus0.r_valid0, bus0.r_data0, rd0, 0, 0);
    check_port("nofwd_p1", bus0.r_valid1, bus0.r_data1, rd1, 0, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    clr = 1'b0; w_en = 1'b0; r_en0 = 1'b0; r_en1 = 1'b0;
    w_addr = '0; r_addr0 = '0; r_addr1 = '0; w_be = '0; w_data = '0;
  endtask

  task automatic randomize_inputs(int clr_odds);
    w_en    = 1'($urandom_range(0, 1));
    w_addr  = AW'($urandom_range(0, DEPTH - 1));
    w_be    = NB'($urandom_range(0, (1 << NB) - 1));
    w_data  = DW'($urandom);
    r_en0   = 1'($urandom_range(0, 1));
    r_en1   = 1'($urandom_range(0, 1));
    r_addr0 = ($urandom_range(0, 2) == 0) ? w_addr : AW'($urandom_range(0, DEPTH - 1));
    r_addr1 = ($urandom_range(0, 2) == 0) ? w_addr : AW'($urandom_range(0, DEPTH - 1));
    clr     = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
  endtask

  // One rising edge: advance the model on the inputs present at the edge, then check.
  task automatic step();
    bit            rd0, rd1;
    logic [DW-1:0] pre0, pre1;
    rd0 = 1'b0;
    rd1 = 1'b0;
    @(posedge clk);
    if (clear_left > 0) begin
      clear_left--;
    end else begin
      pre0 = mem_m[r_addr0];
      pre1 = mem_m[r_addr1];
      if (w_en) mem_m[w_addr] = merge(mem_m[w_addr], w_data, w_be);
      rd0 = r_en0;
      rd1 = r_en1;
      if (rd0) exp_q.push_back(mem_m[r_addr0]);
      if (rd1) exp_q.push_back(mem_m[r_addr1]);
      if (rd0) exp_q.push_back(pre0);
      if (rd1) exp_q.push_back(pre1);
      if (clr) start_clear();
    end
    #1;
    check_outputs(rd0, rd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_ready_fwd", 32'(bus1.ready), 32'd0);
    check("rst_ready_nofwd", 32'(bus0.ready), 32'd0);
    check("rst_valid_fwd", 32'({bus1.r_valid0, bus1.r_valid1}), 32'd0);
    check("rst_valid_nofwd", 32'({bus0.r_valid0, bus0.r_valid1}), 32'd0);
    check("rst_data_fwd", {bus1.r_data0, bus1.r_data1}, 32'd0);
    check("rst_data_nofwd", {bus0.r_data0, bus0.r_data1}, 32'd0);
    start_clear();
    exp_q.delete();
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) hold[d][p] = '0;
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Counts edges until ready, with garbage on the inputs; expects exactly DEPTH.
  task automatic wait_ready(string tag);
    int rise = 0;
    for (int k = 1; k <= 4 * DEPTH && rise == 0; k++) begin
      randomize_inputs(2);
      step();
      if (bus1.ready) rise = k;
    end
    idle();
    check(tag, 32'(rise), 32'(DEPTH));
  endtask

  task automatic write(logic [AW-1:0] a, logic [DW-1:0] d, logic [NB-1:0] be);
    idle();
    w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
    step();
    idle();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      r_en0 = 1'b1; r_en1 = 1'b1;
      r_addr0 = AW'(a); r_addr1 = AW'(DEPTH - 1 - a);
      step();
    end
    idle();
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle();
    do_reset();
    wait_ready("first_sweep_edges");

    // Reset sweep over garbage
    for (int a = 0; a < DEPTH; a++) write(AW'(a), DW'($urandom) | DW'(1), '1);
    do_reset();
    wait_ready("reset_sweep_edges");
    read_all();

    // Byte-enable write
    write(3'd3, 16'hAAAA, 2'b11);
    write(3'd3, 16'h5555, 2'b01);
    r_en0 = 1'b1; r_addr0 = 3'd3;
    step();
    idle();
    check("be_merge_fwd", 32'(bus1.r_data0), 32'h0000_AA55);
    check("be_merge_nofwd", 32'(bus0.r_data0), 32'h0000_AA55);
    write(3'd3, 16'hFFFF, 2'b00);
    r_en1 = 1'b1; r_addr1 = 3'd3;
    step();
    idle();
    check("be_zero_write", 32'(bus1.r_data1), 32'h0000_AA55);

    // Dual read with same-cycle write to the same address
    w_en = 1'b1; w_addr = 3'd5; w_data = 16'h1234; w_be = 2'b11;
    r_en0 = 1'b1; r_en1 = 1'b1; r_addr0 = 3'd5; r_addr1 = 3'd5;
    step();
    idle();
    check("fwd_p0_collide", 32'(bus1.r_data0), 32'h0000_1234);
    check("fwd_p1_collide", 32'(bus1.r_data1), 32'h0000_1234);
    check("nofwd_p0_collide", 32'(bus0.r_data0), 32'h0000_0000);
    check("nofwd_p1_collide", 32'(bus0.r_data1), 32'h0000_0000);
    r_en0 = 1'b1; r_addr0 = 3'd5;
    step();
    idle();
    check("nofwd_next_cycle", 32'(bus0.r_data0), 32'h0000_1234);

    // Idle read hold
    write(3'd1, 16'h00FF, 2'b11);
    r_en0 = 1'b1; r_addr0 = 3'd1;
    step();
    for (int k = 0; k < 4; k++) begin
      randomize_inputs(0);
      r_en0 = 1'b0;
      step();
      check("hold_data", 32'(bus1.r_data0), 32'h0000_00FF);
      check("hold_valid", 32'(bus1.r_valid0), 32'd0);
    end
    idle();

    // Clear request with a read in the same cycle
    for (int a = 0; a < DEPTH; a++) write(AW'(a), DW'($urandom) | DW'(16'h0100), '1);
    clr = 1'b1; r_en0 = 1'b1; r_addr0 = 3'd2;
    step();
    check("clr_read_valid", 32'(bus1.r_valid0), 32'd1);
    check("clr_read_nonzero", 32'(bus1.r_data0 != '0), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      randomize_inputs(2);
      step();
    end
    idle();
    check("clr_ready_back", 32'(bus1.ready), 32'd1);
    read_all();

    // Reset in the middle of a clr sweep
    for (int a = 0; a < DEPTH; a++) write(AW'(a), DW'($urandom), '1);
    clr = 1'b1;
    step();
    idle();
    for (int k = 0; k < 3; k++) step();
    do_reset();
    wait_ready("midsweep_edges");
    read_all();

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      randomize_inputs(40);
      step();
    end
    idle();
    for (int k = 0; k < DEPTH + 1; k++) step();
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
